// File: rtl/tx_pkg.sv
// Shared transmitter configuration types and constants.
// Used by the register bank, the shadow/commit block and the code generator.
package tx_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned MAX_DIG = 32;
  localparam int unsigned PROD_W  = 2 * DATA_W;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } tx_state_e;

  // First failing rule wins; ERR_NONE means the set is usable.
  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_PERIOD = 3'd1,
    ERR_PRT    = 3'd2,
    ERR_NUMDIG = 3'd3,
    ERR_TB     = 3'd4,
    ERR_CHIPS  = 3'd5
  } tx_err_e;

  typedef struct packed {
    logic [DATA_W-1:0] phase;
    logic [DATA_W-1:0] period;
    logic [DATA_W-1:0] prt;
    logic [DATA_W-1:0] codigo;
    logic [DATA_W-1:0] numdig;
    logic [DATA_W-1:0] tb;
  } tx_cfg_t;

endpackage

// File: rtl/tx_cfg_shadow_if.sv
// Request/status bus between the register bank (master) and tx_cfg_shadow (slave).
//  upd_req   : one-cycle pulse, cfg holds a new set
//  cfg       : requested configuration set
//  pending   : a validated set waits for a commit point
//  upd_ack   : one-cycle pulse when the active set changes
//  cfg_err   : sticky reject flag
//  apply_cnt : commit counter
//  rej_cnt   : reject counter
interface tx_cfg_shadow_if;
  import tx_pkg::*;

  logic               upd_req;
  tx_cfg_t            cfg;
  logic               pending;
  logic               upd_ack;
  logic               cfg_err;
  logic [CNT_W-1:0]   apply_cnt;
  logic [CNT_W-1:0]   rej_cnt;

  modport master (
    output upd_req, cfg,
    input  pending, upd_ack, cfg_err, apply_cnt, rej_cnt
  );

  modport slave (
    input  upd_req, cfg,
    output pending, upd_ack, cfg_err, apply_cnt, rej_cnt
  );

endinterface

// File: rtl/tx_cfg_check.sv
// Combinational validator for a transmitter configuration set.
//  i_cfg      : set to check
//  o_valid    : set is usable
//  o_err_code : first failing rule (tx_err_e encoding)
module tx_cfg_check
  import tx_pkg::*;
(
  input  tx_cfg_t    i_cfg,
  output logic       o_valid,
  output logic [2:0] o_err_code
);

  // Full-width product so a huge numdig*tb cannot wrap into a legal value.
  logic [PROD_W-1:0] w_chips;
  assign w_chips = PROD_W'(i_cfg.numdig) * PROD_W'(i_cfg.tb);

  always_comb begin
    o_err_code = 3'(ERR_NONE);
    if (i_cfg.period == '0)
      o_err_code = 3'(ERR_PERIOD);
    else if (i_cfg.prt <= i_cfg.period)
      o_err_code = 3'(ERR_PRT);
    else if ((i_cfg.numdig == '0) || (i_cfg.numdig > DATA_W'(MAX_DIG)))
      o_err_code = 3'(ERR_NUMDIG);
    else if (i_cfg.tb == '0)
      o_err_code = 3'(ERR_TB);
    else if (w_chips > PROD_W'(i_cfg.period))
      o_err_code = 3'(ERR_CHIPS);
    o_valid = (o_err_code == 3'(ERR_NONE));
  end

endmodule

// File: rtl/tx_cfg_shadow.sv
// Shadow register set for the transmitter core: stages a validated config set
// and commits it atomically at the end of a pulse (i_sinc falling) or at once
// while the transmitter is stopped.
//  i_clk, i_rst : clock, asynchronous active-low reset
//  i_start      : run request; o_start is its registered copy
//  i_sinc       : sync gate, high during the pulse
//  io_cfg       : request/status bus (slave side)
//  o_phase..o_tb: active (committed) configuration words
module tx_cfg_shadow
  import tx_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_sinc,
  tx_cfg_shadow_if.slave     io_cfg,
  output logic               o_start,
  output logic [DATA_W-1:0]  o_phase,
  output logic [DATA_W-1:0]  o_period,
  output logic [DATA_W-1:0]  o_prt,
  output logic [DATA_W-1:0]  o_codigo,
  output logic [DATA_W-1:0]  o_numdig,
  output logic [DATA_W-1:0]  o_tb
);

  tx_state_e         r_state;
  tx_state_e         w_state_nxt;
  logic              r_sinc_d;
  logic              r_start;
  tx_cfg_t           r_stage;
  tx_cfg_t           r_active;
  logic              r_upd_ack;
  logic              r_cfg_err;
  logic [CNT_W-1:0]  r_apply_cnt;
  logic [CNT_W-1:0]  r_rej_cnt;

  logic              w_valid;
  logic [2:0]        w_err_code;
  logic              w_req_ok;
  logic              w_req_bad;
  logic              w_sinc_fall;
  logic              w_load;
  logic              w_commit;

  tx_cfg_check u_check (
    .i_cfg      (io_cfg.cfg),
    .o_valid    (w_valid),
    .o_err_code (w_err_code)
  );

  assign w_req_ok    = io_cfg.upd_req & w_valid;
  assign w_req_bad   = io_cfg.upd_req & (w_err_code != 3'(ERR_NONE));
  assign w_sinc_fall = r_sinc_d & ~i_sinc;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state; a request in the commit cycle re-arms PENDING with the new words.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req_ok) begin
          w_load      = 1'b1;
          w_state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (!r_start || w_sinc_fall) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        if (w_req_ok) begin
          w_load      = 1'b1;
          w_state_nxt = ST_PENDING;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: staging, active set, flags and counters.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sinc_d    <= 1'b0;
      r_start     <= 1'b0;
      r_stage     <= '0;
      r_active    <= '0;
      r_upd_ack   <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_apply_cnt <= '0;
      r_rej_cnt   <= '0;
    end else begin
      r_sinc_d  <= i_sinc;
      r_start   <= i_start;
      r_upd_ack <= w_commit;
      if (w_load) r_stage <= io_cfg.cfg;
      // Non-blocking copy: a same-cycle reload still commits the old staging.
      if (w_commit) begin
        r_active    <= r_stage;
        r_apply_cnt <= r_apply_cnt + CNT_W'(1);
      end
      if (w_req_ok) begin
        r_cfg_err <= 1'b0;
      end else if (w_req_bad) begin
        r_cfg_err <= 1'b1;
        r_rej_cnt <= r_rej_cnt + CNT_W'(1);
      end
    end
  end

  assign o_start           = r_start;
  assign o_phase           = r_active.phase;
  assign o_period          = r_active.period;
  assign o_prt             = r_active.prt;
  assign o_codigo          = r_active.codigo;
  assign o_numdig          = r_active.numdig;
  assign o_tb              = r_active.tb;
  assign io_cfg.pending    = (r_state == ST_PENDING);
  assign io_cfg.upd_ack    = r_upd_ack;
  assign io_cfg.cfg_err    = r_cfg_err;
  assign io_cfg.apply_cnt  = r_apply_cnt;
  assign io_cfg.rej_cnt    = r_rej_cnt;

endmodule
